apb_timer_lite: RTL

APB_TIMER_LITE -- requirements
Module: apb_timer_lite

---
 rtl/apb_timer_lite_pkg.sv | 40 ++++
 rtl/timer_lite_core.sv | 86 ++++++++
 rtl/apb_timer_lite.sv | 78 +++++++
 3 files changed

// File: rtl/apb_timer_lite_pkg.sv
// Shared constants for the two-timer APB peripheral: register decode,
// CTRL field layout and reset values.
package apb_timer_lite_pkg;

    localparam int unsigned TIMER_W   = 32;
    localparam int unsigned PRESC_W   = 8;
    localparam int unsigned CTRL_PS_W = 3;

    // Byte offsets of the register map; bit 4 selects timer B.
    localparam logic [11:0] OFF_A_COUNT = 12'h000;
    localparam logic [11:0] OFF_A_CTRL  = 12'h004;
    localparam logic [11:0] OFF_A_CMP   = 12'h008;
    localparam logic [11:0] OFF_B_COUNT = 12'h010;
    localparam logic [11:0] OFF_B_CTRL  = 12'h014;
    localparam logic [11:0] OFF_B_CMP   = 12'h018;
    localparam int unsigned TIMER_SEL_BIT = 4;

    // Register selector within one timer, taken from PADDR[3:2].
    typedef enum logic [1:0] {
        REG_COUNT = 2'd0,
        REG_CTRL  = 2'd1,
        REG_CMP   = 2'd2,
        REG_NONE  = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN_BIT = 0;
    localparam int unsigned CTRL_PS_LSB = 1;

    localparam logic [TIMER_W-1:0] CMP_RESET = 32'hFFFF_FFFF;

    function automatic logic [TIMER_W-1:0] ctrl_word(input logic en,
                                                     input logic [CTRL_PS_W-1:0] ps);
        logic [TIMER_W-1:0] w;
        w = '0;
        w[CTRL_EN_BIT] = en;
        w[CTRL_PS_LSB +: CTRL_PS_W] = ps;
        return w;
    endfunction

endpackage

// File: rtl/timer_lite_core.sv
// One 32-bit timer: power-of-two prescaler, free-running COUNT with compare
// reload and overflow wrap, and registered one-cycle irq pulses.
module timer_lite_core
    import apb_timer_lite_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_count,
    input  logic                 wr_ctrl,
    input  logic                 wr_cmp,
    input  logic [TIMER_W-1:0]   wdata,
    output logic [TIMER_W-1:0]   count,
    output logic [TIMER_W-1:0]   cmp,
    output logic                 en,
    output logic [CTRL_PS_W-1:0] ps,
    output logic                 irq_cmp,
    output logic                 irq_ovf
);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_mask;
    logic               tick;
    logic               hit_cmp;
    logic               hit_ovf;

    // Tick when the low PS bits of the prescaler are all ones: every 2^PS cycles.
    assign presc_mask = (PRESC_W'(1) << ps) - PRESC_W'(1);
    assign tick       = en && ((presc & presc_mask) == presc_mask);

    // A COUNT write on the tick edge swallows the tick, including its irqs.
    assign hit_cmp = tick && !wr_count && (count == cmp);
    assign hit_ovf = tick && !wr_count && (count == '1);

    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // so a CMP write on a tick edge still compares against the old CMP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= 1'b0;
            ps <= '0;
        end else if (wr_ctrl) begin
            en <= wdata[CTRL_EN_BIT];
            ps <= wdata[CTRL_PS_LSB +: CTRL_PS_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (wr_ctrl || !en) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wdata;
        end else if (hit_cmp || hit_ovf) begin
            count <= '0;
        end else if (tick) begin
            count <= count + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp <= CMP_RESET;
        end else if (wr_cmp) begin
            cmp <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_cmp <= 1'b0;
            irq_ovf <= 1'b0;
        end else begin
            irq_cmp <= hit_cmp;
            irq_ovf <= hit_ovf;
        end
    end

endmodule

// File: rtl/apb_timer_lite.sv
// APB slave wrapping two independent timer_lite_core instances; owns the
// address decode, error response and combinational read mux.
module apb_timer_lite
    import apb_timer_lite_pkg::*;
#(
    parameter int N_TIMERS = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [11:0]           PADDR,
    input  logic [31:0]           PWDATA,
    input  logic                  PWRITE,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [2*N_TIMERS-1:0] irq_o
);

    logic                 access;
    logic                 mapped;
    logic                 wr_en;
    logic                 timer_sel;
    reg_sel_e             reg_sel;
    logic                 addr_unused;

    logic [TIMER_W-1:0]   count [N_TIMERS];
    logic [TIMER_W-1:0]   cmp   [N_TIMERS];
    logic                 en    [N_TIMERS];
    logic [CTRL_PS_W-1:0] ps    [N_TIMERS];

    // Byte-lane bits carry no meaning for word registers.
    assign addr_unused = ^PADDR[1:0];

    assign reg_sel   = reg_sel_e'(PADDR[3:2]);
    assign timer_sel = PADDR[TIMER_SEL_BIT];
    assign mapped    = (PADDR[11:5] == '0) && (reg_sel != REG_NONE);
    assign access    = PSEL && PENABLE;
    assign wr_en     = access && PWRITE && mapped;

    assign PREADY  = 1'b1;
    assign PSLVERR = access && !mapped;

    for (genvar i = 0; i < N_TIMERS; i++) begin : g_timer
        logic sel;
        assign sel = wr_en && (timer_sel == 1'(i));

        timer_lite_core u_core (
            .clk      (HCLK),
            .rst_n    (HRESETn),
            .wr_count (sel && (reg_sel == REG_COUNT)),
            .wr_ctrl  (sel && (reg_sel == REG_CTRL)),
            .wr_cmp   (sel && (reg_sel == REG_CMP)),
            .wdata    (PWDATA),
            .count    (count[i]),
            .cmp      (cmp[i]),
            .en       (en[i]),
            .ps       (ps[i]),
            .irq_cmp  (irq_o[2*i+1]),
            .irq_ovf  (irq_o[2*i])
        );
    end

    // NOTE: PRDATA gets a default before any branch so the mux never infers a latch.
    always_comb begin
        PRDATA = '0;
        if (PSEL && mapped) begin
            case (reg_sel)
                REG_COUNT: PRDATA = count[timer_sel];
                REG_CTRL:  PRDATA = ctrl_word(en[timer_sel], ps[timer_sel]);
                REG_CMP:   PRDATA = cmp[timer_sel];
                default:   PRDATA = '0;
            endcase
        end
    end

endmodule
